// File: rtl/iob_iob2wishbone.sv
// rtl/iob_iob2wishbone.sv - IOb native to Wishbone classic single-transfer bridge
// Optional bus-timeout logic is enabled with `define IOB2WB_TIMEOUT_EN.
module iob_iob2wishbone #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk_i,
  input  logic                wb_rst_i,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ready_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   wb_addr_o,
  output logic [DATA_W/8-1:0] wb_select_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic [DATA_W-1:0]   wb_data_o,
  input  logic [DATA_W-1:0]   wb_data_i,
  input  logic                wb_ack_i,
  input  logic                wb_error_i
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state;
  logic   done;
  logic   done_err;

`ifdef IOB2WB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             tmo_hit;

  assign tmo_hit  = (wait_cnt == TMO_LAST);
  assign done     = wb_ack_i | wb_error_i | tmo_hit;
  // A real ack on the last counted cycle beats the timeout.
  assign done_err = wb_error_i | (tmo_hit & ~wb_ack_i);

  always_ff @(posedge clk_i) begin
    if (wb_rst_i) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if (!done) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign done           = wb_ack_i | wb_error_i;
  assign done_err       = wb_error_i;
`endif

  always_ff @(posedge clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      rdata_o     <= '0;
      ready_o     <= 1'b0;
      err_o       <= 1'b0;
      wb_addr_o   <= '0;
      wb_select_o <= '0;
      wb_we_o     <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_data_o   <= '0;
    end else begin
      ready_o <= 1'b0;
      err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            state       <= BUSY;
            wb_addr_o   <= address_i;
            wb_data_o   <= wdata_i;
            wb_select_o <= (|wstrb_i) ? wstrb_i : '1;
            wb_we_o     <= |wstrb_i;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
          end
        end
        BUSY: begin
          if (done) begin
            state    <= IDLE;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            ready_o  <= 1'b1;
            err_o    <= done_err;
            // wb_we_o still reflects the finishing transfer here.
            if (!wb_we_o) begin
              rdata_o <= done_err ? '0 : wb_data_i;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_iob2wishbone.sv
// tb/tb_iob_iob2wishbone.sv - self-checking bench for iob_iob2wishbone
module tb_iob_iob2wishbone;

  logic        clk_i = 1'b0;
  logic        wb_rst_i;
  logic        valid_i;
  logic [31:0] address_i;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic [31:0] rdata_o;
  logic        ready_o;
  logic        err_o;
  logic [31:0] wb_addr_o;
  logic [3:0]  wb_select_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic        wb_error_i;

  int checks   = 0;
  int failures = 0;
  logic [31:0] rdata_m;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          dly;
    int          mode;   // 0 ack, 1 error, 2 both
    logic [31:0] sd;
    logic        exp_we;
    logic [3:0]  exp_sel;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[7];

  always #5 clk_i = ~clk_i;

  iob_iob2wishbone #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk_i(clk_i), .wb_rst_i(wb_rst_i), .valid_i(valid_i), .address_i(address_i),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .rdata_o(rdata_o), .ready_o(ready_o),
    .err_o(err_o), .wb_addr_o(wb_addr_o), .wb_select_o(wb_select_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i),
    .wb_ack_i(wb_ack_i), .wb_error_i(wb_error_i)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input int dly, input int mode, input logic [31:0] sd,
                     input logic exp_we, input logic [3:0] exp_sel,
                     input logic exp_err, input logic [31:0] exp_rd);
    valid_i   = 1'b1;
    address_i = a;
    wdata_i   = wd;
    wstrb_i   = ws;
    step();
    valid_i   = 1'b0;
    address_i = $urandom;
    wdata_i   = $urandom;
    wstrb_i   = 4'($urandom);
    chk("stb_first", {63'd0, wb_stb_o}, 64'd1);
    chk("cyc_first", {63'd0, wb_cyc_o}, 64'd1);
    chk("we", {63'd0, wb_we_o}, {63'd0, exp_we});
    chk("select", {60'd0, wb_select_o}, {60'd0, exp_sel});
    chk("addr", {32'd0, wb_addr_o}, {32'd0, a});
    chk("wdata", {32'd0, wb_data_o}, {32'd0, wd});
    for (int i = 0; i < dly; i++) begin
      chk("ready_wait", {63'd0, ready_o}, 64'd0);
      step();
      chk("stb_wait", {63'd0, wb_stb_o}, 64'd1);
    end
    wb_ack_i   = (mode != 1);
    wb_error_i = (mode != 0);
    wb_data_i  = sd;
    step();
    wb_ack_i   = 1'b0;
    wb_error_i = 1'b0;
    wb_data_i  = $urandom;
    chk("ready_done", {63'd0, ready_o}, 64'd1);
    chk("err_done", {63'd0, err_o}, {63'd0, exp_err});
    chk("rdata_done", {32'd0, rdata_o}, {32'd0, exp_rd});
    chk("stb_done", {63'd0, wb_stb_o}, 64'd0);
    chk("we_idle", {63'd0, wb_we_o}, 64'd0);
    step();
    chk("ready_pulse", {63'd0, ready_o}, 64'd0);
    chk("err_low", {63'd0, err_o}, 64'd0);
    chk("rdata_hold", {32'd0, rdata_o}, {32'd0, exp_rd});
    chk("addr_hold", {32'd0, wb_addr_o}, {32'd0, a});
    chk("sel_hold", {60'd0, wb_select_o}, {60'd0, exp_sel});
  endtask

  initial begin
    logic [3:0]  ws;
    logic [31:0] sd;
    int          mode;
    int          n;

    tbl[0] = '{32'h10, 32'h0,        4'h0, 3, 0, 32'hDEADBEEF, 1'b0, 4'hF, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{32'h20, 32'h12345678, 4'h3, 0, 0, 32'hAAAA5555, 1'b1, 4'h3, 1'b0, 32'hDEADBEEF};
    tbl[2] = '{32'h30, 32'h0,        4'h0, 1, 1, 32'h11112222, 1'b0, 4'hF, 1'b1, 32'h0};
    tbl[3] = '{32'h40, 32'h0,        4'h0, 0, 0, 32'hCAFEF00D, 1'b0, 4'hF, 1'b0, 32'hCAFEF00D};
    tbl[4] = '{32'h44, 32'h87654321, 4'hF, 2, 1, 32'h0,        1'b1, 4'hF, 1'b1, 32'hCAFEF00D};
    tbl[5] = '{32'h48, 32'h0,        4'h0, 1, 2, 32'h77778888, 1'b0, 4'hF, 1'b1, 32'h0};
    tbl[6] = '{32'h4C, 32'hA5A5A5A5, 4'h8, 0, 0, 32'h12341234, 1'b1, 4'h8, 1'b0, 32'h0};

    wb_rst_i = 1'b1; valid_i = 1'b0; address_i = '0; wdata_i = '0; wstrb_i = '0;
    wb_data_i = '0; wb_ack_i = 1'b0; wb_error_i = 1'b0;
    step(); step(); step();
    chk("rst_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_err", {63'd0, err_o}, 64'd0);
    chk("rst_rdata", {32'd0, rdata_o}, 64'd0);
    chk("rst_cyc", {63'd0, wb_cyc_o}, 64'd0);
    chk("rst_stb", {63'd0, wb_stb_o}, 64'd0);
    chk("rst_we", {63'd0, wb_we_o}, 64'd0);
    chk("rst_addr", {32'd0, wb_addr_o}, 64'd0);
    chk("rst_sel", {60'd0, wb_select_o}, 64'd0);
    chk("rst_data", {32'd0, wb_data_o}, 64'd0);
    wb_rst_i = 1'b0;
    step();

    for (int i = 0; i < 7; i++)
      txn(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].dly, tbl[i].mode, tbl[i].sd,
          tbl[i].exp_we, tbl[i].exp_sel, tbl[i].exp_err, tbl[i].exp_rd);
    rdata_m = 32'h0;

    // Reference model: writes leave read data alone, failed reads return zero.
    for (int i = 0; i < 40; i++) begin
      ws   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      mode = $urandom_range(0, 2);
      sd   = $urandom;
      if (ws == 4'h0) rdata_m = (mode != 0) ? 32'h0 : sd;
      txn($urandom, $urandom, ws, $urandom_range(0, 3), mode, sd,
          ws != 4'h0, (ws != 4'h0) ? ws : 4'hF, mode != 0, rdata_m);
    end

    // Reset in the middle of a transfer
    valid_i = 1'b1; address_i = 32'h50; wstrb_i = 4'h0;
    step();
    valid_i = 1'b0;
    chk("rb_stb_before", {63'd0, wb_stb_o}, 64'd1);
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0;
    chk("rb_stb", {63'd0, wb_stb_o}, 64'd0);
    chk("rb_cyc", {63'd0, wb_cyc_o}, 64'd0);
    chk("rb_ready", {63'd0, ready_o}, 64'd0);
    chk("rb_addr", {32'd0, wb_addr_o}, 64'd0);
    chk("rb_sel", {60'd0, wb_select_o}, 64'd0);
    chk("rb_rdata", {32'd0, rdata_o}, 64'd0);
    step();
    chk("rb_ready_after", {63'd0, ready_o}, 64'd0);
    chk("rb_stb_after", {63'd0, wb_stb_o}, 64'd0);

    // Request presented together with reset is dropped
    wb_rst_i = 1'b1; valid_i = 1'b1; address_i = 32'h60;
    step();
    wb_rst_i = 1'b0; valid_i = 1'b0;
    chk("rv_stb", {63'd0, wb_stb_o}, 64'd0);
    step();
    chk("rv_stb_after", {63'd0, wb_stb_o}, 64'd0);

    // Stray ack/error while idle
    wb_ack_i = 1'b1; wb_error_i = 1'b1;
    step();
    wb_ack_i = 1'b0; wb_error_i = 1'b0;
    chk("idle_ack_ready", {63'd0, ready_o}, 64'd0);
    step();
    chk("idle_ack_ready2", {63'd0, ready_o}, 64'd0);
    chk("idle_ack_stb", {63'd0, wb_stb_o}, 64'd0);

    // Back-to-back with ignored requests during BUSY
    valid_i = 1'b1; address_i = 32'h100; wstrb_i = 4'h0;
    step();
    address_i = 32'h999;
    chk("bb_stb1", {63'd0, wb_stb_o}, 64'd1);
    wb_ack_i = 1'b1; wb_data_i = 32'h0BADF00D;
    step();
    wb_ack_i = 1'b0;
    chk("bb_ready1", {63'd0, ready_o}, 64'd1);
    chk("bb_rdata1", {32'd0, rdata_o}, 64'h0BADF00D);
    chk("bb_stb_gap", {63'd0, wb_stb_o}, 64'd0);
    valid_i = 1'b1; address_i = 32'h200; wdata_i = 32'h55; wstrb_i = 4'hF;
    step();
    chk("bb_stb2", {63'd0, wb_stb_o}, 64'd1);
    chk("bb_addr2", {32'd0, wb_addr_o}, 64'h200);
    chk("bb_we2", {63'd0, wb_we_o}, 64'd1);
    address_i = 32'h300; wstrb_i = 4'h0;
    step(); step();
    chk("bb_addr_busy", {32'd0, wb_addr_o}, 64'h200);
    valid_i = 1'b0; wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    chk("bb_ready2", {63'd0, ready_o}, 64'd1);
    chk("bb_err2", {63'd0, err_o}, 64'd0);
    chk("bb_rdata2", {32'd0, rdata_o}, 64'h0BADF00D);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bb_no_extra", {63'd0, wb_stb_o}, 64'd0);
    end

    // Unanswered read
    valid_i = 1'b1; address_i = 32'h400; wstrb_i = 4'h0;
    step();
    valid_i = 1'b0;
    n = 0;
`ifdef IOB2WB_TIMEOUT_EN
    while (wb_stb_o && n < 20) begin
      n++;
      step();
    end
    chk("tmo_stb_cycles", 64'(n), 64'd4);
    chk("tmo_ready", {63'd0, ready_o}, 64'd1);
    chk("tmo_err", {63'd0, err_o}, 64'd1);
    chk("tmo_rdata", {32'd0, rdata_o}, 64'd0);
`else
    while (wb_stb_o && n < 1000) begin
      chk("wait_no_ready", {63'd0, ready_o}, 64'd0);
      n++;
      step();
    end
    chk("wait_stb_cycles", 64'(n), 64'd1000);
    chk("wait_stb_still", {63'd0, wb_stb_o}, 64'd1);
    wb_ack_i = 1'b1; wb_data_i = 32'h600DCAFE;
    step();
    wb_ack_i = 1'b0;
    chk("wait_ready", {63'd0, ready_o}, 64'd1);
    chk("wait_err", {63'd0, err_o}, 64'd0);
    chk("wait_rdata", {32'd0, rdata_o}, 64'h600DCAFE);
`endif
    step();
    chk("final_ready", {63'd0, ready_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iob_iob2wishbone.md
IOB_IOB2WISHBONE -- requirements
Module: iob_iob2wishbone

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; DATA_W/8 strobe/select bits.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, maximum Wishbone wait cycles; used only under IOB2WB_TIMEOUT_EN.
REQ-004 SHALL have ports:
- clk_i  in  1  sole clock; all flops rising-edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- valid_i  in  1  IOb request pulse, one cycle.
- address_i  in  ADDR_W  IOb address.
- wdata_i  in  DATA_W  IOb write data.
- wstrb_i  in  DATA_W/8  IOb byte strobes; all zero means read.
- rdata_o  out  DATA_W  IOb read data.
- ready_o  out  1  IOb completion pulse.
- err_o  out  1  error flag, valid with ready_o.
- wb_addr_o  out  ADDR_W  Wishbone address.
- wb_select_o  out  DATA_W/8  Wishbone byte select.
- wb_we_o  out  1  Wishbone write enable.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_data_o  out  DATA_W  Wishbone write data.
- wb_data_i  in  DATA_W  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_error_i  in  1  Wishbone error termination.

Function
REQ-005 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-006 IDLE: valid_i=1 at a rising edge SHALL register address_i, wdata_i, wstrb_i and move to BUSY.
REQ-007 BUSY: wb_cyc_o=wb_stb_o=1; wb_addr_o, wb_data_o come from registers; wb_we_o=|wstrb; wb_select_o=wstrb on writes, all ones on reads.
REQ-008 IDLE: wb_cyc_o=wb_stb_o=wb_we_o=0; wb_addr_o, wb_select_o and wb_data_o hold their last values.
REQ-009 BUSY, wb_ack_i=1 or wb_error_i=1 sampled: next cycle SHALL be IDLE with cyc/stb=0 and ready_o=1 for exactly one cycle.
REQ-010 Minimum latency: valid_i in cycle 0, stb in cycle 1, ack in cycle 1, ready_o in cycle 2.
REQ-011 Read ack: rdata_o SHALL load wb_data_i and hold until the next read completion.
REQ-012 Write ack: rdata_o SHALL be unchanged.
REQ-013 Completion by wb_error_i: err_o=1 with ready_o; on a read, rdata_o=0.
REQ-014 ack and error both high: SHALL be treated as error.
REQ-015 err_o SHALL be 0 whenever ready_o=0.
REQ-016 valid_i in BUSY, or in the ready_o cycle's preceding edge, SHALL be ignored; no queueing.
REQ-017 valid_i in the same cycle as ready_o=1 (state IDLE) SHALL be accepted normally (back-to-back).
REQ-018 wb_ack_i or wb_error_i while IDLE SHALL be ignored.

Reset
REQ-019 wb_rst_i=1 at an edge SHALL force IDLE and clear all registers, giving all-zero outputs: ready_o=0, err_o=0, rdata_o=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_addr_o=0, wb_select_o=0, wb_data_o=0.
REQ-020 Reset during BUSY SHALL drop cyc/stb on the next edge without producing ready_o.
REQ-021 A request presented with wb_rst_i=1 SHALL be discarded.

Configuration
REQ-022 With IOB2WB_TIMEOUT_EN defined, a counter SHALL clear on entering BUSY and increment each BUSY cycle without ack/err.
- When BUSY cycles without ack/err reach TIMEOUT_CYC, the next cycle SHALL be IDLE with ready_o=1, err_o=1, and rdata_o=0 on reads.
- ack on the final counted cycle SHALL win over timeout.
REQ-023 Without IOB2WB_TIMEOUT_EN, BUSY SHALL wait indefinitely and no counter logic is synthesized.

Verification
REQ-024 Read: valid_i, address_i=0x10, wstrb_i=0; slave acks 3 cycles after stb with data 0xDEADBEEF -> wb_we_o=0, wb_select_o=0xF, ready_o one cycle, rdata_o=0xDEADBEEF, err_o=0.
REQ-025 Write: address_i=0x20, wdata_i=0x12345678, wstrb_i=0x3; ack same cycle as stb -> wb_we_o=1, wb_select_o=0x3, ready_o in cycle 2, rdata_o unchanged.
REQ-026 Error: read terminated by wb_error_i -> ready_o=1, err_o=1, rdata_o=0; next request completes with err_o=0.
REQ-027 Back-to-back: second valid_i in the ready_o cycle -> second stb one cycle later; extra valid_i during BUSY produces no extra Wishbone cycle.
REQ-028 Reset: wb_rst_i pulse in BUSY -> cyc/stb=0 next cycle, no ready_o, all outputs 0.
REQ-029 Timeout (macro on, TIMEOUT_CYC=4): no ack -> stb high exactly 4 cycles, then ready_o=1, err_o=1; macro off -> stb stays high for 1000 cycles.
